// File: rtl/spi_master.sv
// Mode-0 SPI master: MSB-first serialiser with a matching receive shifter.
// Every half-period of sclk lasts CLK_DIV clk cycles; cs frames one word.
module spi_master #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              last_bit;

    assign tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LEAD;
            LEAD:    if (tick) state_d = HIGH;
            HIGH:    if (tick) state_d = last_bit ? TRAIL : LOW;
            LOW:     if (tick) state_d = HIGH;
            TRAIL:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (start) begin
                    tx_sr_d = tx_data;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LEAD, LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (!last_bit) begin
                        tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            TRAIL: begin
                // Clearing the shifter also returns mosi to 0.
                if (tick) begin
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    tx_sr_d   = '0;
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                end
            end
            default: begin
                div_cnt_d = '0;
            end
        endcase
    end

    assign mosi    = tx_sr_q[DATA_W-1];
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=2 with a reply
// slave model, one at CLK_DIV=1 with mosi looped back to miso.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic [7:0] rx2;
    logic       busy2, done2, sclk2, cs2, mosi2;
    logic       miso2 = 1'b0;

    logic       start1 = 1'b0;
    logic [7:0] tx1 = 8'h00;
    logic [7:0] rx1;
    logic       busy1, done1, sclk1, cs1, mosi1;
    logic       miso1;

    int         tests = 0;
    int         fails = 0;
    int         done2_cnt = 0;

    logic [7:0] rep2 = 8'h00;
    int         idx2 = 0;
    logic       fresh2 = 1'b1;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(2), .DATA_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .rx_data(rx2), .busy(busy2), .done(done2), .sclk(sclk2),
        .cs(cs2), .mosi(mosi2), .miso(miso2)
    );

    spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1),
        .rx_data(rx1), .busy(busy1), .done(done1), .sclk(sclk1),
        .cs(cs1), .mosi(mosi1), .miso(miso1)
    );

    assign miso1 = mosi1;

    // Reply slave: MSB at cs fall, next bit after every sclk fall.
    always @(negedge cs2 or posedge cs2 or negedge sclk2) begin
        if (cs2 !== 1'b0) begin
            fresh2 = 1'b1;
        end else begin
            if (fresh2) begin
                idx2   = 7;
                fresh2 = 1'b0;
            end else begin
                idx2 = idx2 - 1;
            end
            miso2 = (idx2 >= 0) ? rep2[idx2] : 1'b0;
        end
    end

    always @(negedge clk) if (done2 === 1'b1) done2_cnt++;

    task automatic test_reset();
        start2 = 1'b1; tx2 = 8'hE7;
        start1 = 1'b1; tx1 = 8'h81;
        #3 rst = 1'b0;
        #1;
        tests++;
        if ({cs2, sclk2, mosi2, busy2, done2} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctl2 got %b want 10000",
                     {cs2, sclk2, mosi2, busy2, done2});
        end
        tests++;
        if (rx2 !== 8'h00) begin
            fails++;
            $display("FAIL reset_rx2 got %h want 00", rx2);
        end
        tests++;
        if ({cs1, sclk1, mosi1, busy1, done1, rx1} !== {5'b10000, 8'h00}) begin
            fails++;
            $display("FAIL reset_dut1 got %b want 1000000000000",
                     {cs1, sclk1, mosi1, busy1, done1, rx1});
        end
        start2 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] tx;
        int k;
        int done_t;
        logic prev;
        tx = 8'h5A; rep2 = 8'hA5;
        @(negedge clk);
        start2 = 1'b1; tx2 = tx;
        @(posedge clk); #1;
        start2 = 1'b0;
        tests++;
        if ({cs2, busy2, mosi2} !== 3'b010) begin
            fails++;
            $display("FAIL basic_e0 got %b want 010", {cs2, busy2, mosi2});
        end
        k = 0; done_t = -1; prev = sclk2;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (sclk2 === 1'b1 && prev === 1'b0) begin
                k++;
                tests++;
                if (t != 4 * k - 2) begin
                    fails++;
                    $display("FAIL basic_rise%0d at %0d want %0d",
                             k, t, 4 * k - 2);
                end
                tests++;
                if (mosi2 !== tx[8-k]) begin
                    fails++;
                    $display("FAIL basic_mosi%0d got %b want %b",
                             k, mosi2, tx[8-k]);
                end
            end
            if (done2 === 1'b1 && done_t < 0) begin
                done_t = t;
                tests++;
                if (cs2 !== 1'b1 || rx2 !== 8'hA5) begin
                    fails++;
                    $display("FAIL basic_end cs %b rx %h want 1 a5",
                             cs2, rx2);
                end
            end
            prev = sclk2;
        end
        tests++;
        if (k != 8) begin
            fails++;
            $display("FAIL basic_rises got %0d want 8", k);
        end
        tests++;
        if (done_t != 34) begin
            fails++;
            $display("FAIL basic_done_t got %0d want 34", done_t);
        end
    endtask

    task automatic test_start_busy();
        logic [7:0] seen;
        int k;
        int d0;
        logic prev;
        rep2 = 8'h3E;
        @(negedge clk);
        start2 = 1'b1; tx2 = 8'h5A;
        @(posedge clk); #1;
        start2 = 1'b0;
        d0 = done2_cnt; k = 0; seen = 8'h00; prev = sclk2;
        for (int t = 1; t <= 50; t++) begin
            @(posedge clk); #1;
            if (sclk2 === 1'b1 && prev === 1'b0) begin
                seen = {seen[6:0], mosi2};
                k++;
            end
            prev = sclk2;
            start2 = (t == 9);
            tx2 = (t == 9) ? 8'hFF : 8'h5A;
        end
        start2 = 1'b0;
        tests++;
        if (seen !== 8'h5A || k != 8) begin
            fails++;
            $display("FAIL busy_stream got %h/%0d want 5a/8", seen, k);
        end
        tests++;
        if (done2_cnt - d0 != 1) begin
            fails++;
            $display("FAIL busy_dones got %0d want 1", done2_cnt - d0);
        end
        tests++;
        if (rx2 !== 8'h3E || cs2 !== 1'b1) begin
            fails++;
            $display("FAIL busy_rx got %h cs %b want 3e 1", rx2, cs2);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int found;
        rep2 = 8'h77;
        @(negedge clk);
        start2 = 1'b1; tx2 = 8'hC5;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        tests++;
        if (sclk2 !== 1'b1) begin
            fails++;
            $display("FAIL mid_rise3 got %b want 1", sclk2);
        end
        d0 = done2_cnt;
        rst = 1'b0;
        #1;
        tests++;
        if ({cs2, sclk2, mosi2, busy2, done2, rx2} !== {5'b10000, 8'h00}) begin
            fails++;
            $display("FAIL mid_rst got %b want 1000000000000",
                     {cs2, sclk2, mosi2, busy2, done2, rx2});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (done2_cnt != d0 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL mid_nodone got %0d busy %b want %0d 0",
                     done2_cnt, busy2, d0);
        end
        rep2 = 8'h96;
        start2 = 1'b1; tx2 = 8'h3C;
        @(posedge clk); #1;
        start2 = 1'b0;
        found = 0;
        for (int t = 1; t <= 60 && found == 0; t++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1) found = t;
        end
        tests++;
        if (found != 34 || rx2 !== 8'h96) begin
            fails++;
            $display("FAIL mid_after done_t %0d rx %h want 34 96",
                     found, rx2);
        end
    endtask

    task automatic test_back_to_back();
        logic hist [0:40];
        logic [7:0] rxa, rxb;
        int ta, tb2, lo_a, lo_b;
        logic sent;
        @(negedge clk);
        start1 = 1'b1; tx1 = 8'h00;
        @(posedge clk); #1;
        start1 = 1'b0;
        hist[0] = cs1;
        ta = -1; tb2 = -1; sent = 1'b0; rxa = 8'hxx; rxb = 8'hxx;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            hist[t] = cs1;
            start1 = 1'b0;
            if (done1 === 1'b1) begin
                if (!sent) begin
                    ta = t; rxa = rx1; sent = 1'b1;
                    start1 = 1'b1; tx1 = 8'hFF;
                end else if (tb2 < 0) begin
                    tb2 = t; rxb = rx1;
                end
            end
        end
        start1 = 1'b0;
        lo_a = 0; lo_b = 0;
        for (int t = 0; t <= 16; t++) if (hist[t] === 1'b0) lo_a++;
        for (int t = 18; t <= 34; t++) if (hist[t] === 1'b0) lo_b++;
        tests++;
        if (ta != 17 || tb2 != 35) begin
            fails++;
            $display("FAIL b2b_done_t got %0d,%0d want 17,35", ta, tb2);
        end
        tests++;
        if (lo_a != 17 || lo_b != 17) begin
            fails++;
            $display("FAIL b2b_cs_low got %0d,%0d want 17,17", lo_a, lo_b);
        end
        tests++;
        if (hist[17] !== 1'b1 || hist[35] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_cs_gap got %b,%b want 1,1",
                     hist[17], hist[35]);
        end
        tests++;
        if (rxa !== 8'h00 || rxb !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_rx got %h,%h want 00,ff", rxa, rxb);
        end
    endtask

    task automatic test_loopback();
        int found;
        @(negedge clk);
        start1 = 1'b1; tx1 = 8'hC3;
        @(posedge clk); #1;
        start1 = 1'b0;
        found = 0;
        for (int t = 1; t <= 40 && found == 0; t++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) found = t;
        end
        tests++;
        if (found != 17 || rx1 !== 8'hC3) begin
            fails++;
            $display("FAIL loop_rx done_t %0d rx %h want 17 c3",
                     found, rx1);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (rx1 !== 8'hC3 || cs1 !== 1'b1) begin
            fails++;
            $display("FAIL loop_hold rx %h cs %b want c3 1", rx1, cs1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (3) @(negedge clk);
        test_start_busy();
        repeat (3) @(negedge clk);
        test_reset_mid();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
